// File: rtl/accel_dispatch.sv
// Purpose : round-robin issue of per-thread header-compare requests to the accelerator, with per-thread result hold.
// Latency : grant in cycle 0, start_out in cycle 1; a completion in cycle k gives rsp_valid in cycle k+1.
// Backpres: a thread stays not-ready (req_ready=0) from grant until its held result is acknowledged.
//
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   req_valid/req_header/req_compare/req_ready   per-thread request side
//   header_out/compare_value_out/start_out/thread_id_out   accelerator issue (registered)
//   action_done_in/action_in/thread_id_in        accelerator completion
//   rsp_valid/rsp_action/rsp_ack                 per-thread result hold and acknowledge
//   err_unexpected                               sticky: completion for a non-pending thread
//   stat_grants/stat_matches                     counters, built only with ACCEL_DISPATCH_STATS_EN
// Optional feature macro: ACCEL_DISPATCH_STATS_EN (undefined: counters tied to zero).
module accel_dispatch #(
    parameter int NUM_THREADS = 8,
    parameter int HDR_W       = 64,
    parameter int CMP_W       = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_THREADS-1:0]   req_valid,
    input  logic [NUM_THREADS*HDR_W-1:0] req_header,
    input  logic [NUM_THREADS*CMP_W-1:0] req_compare,
    output logic [NUM_THREADS-1:0]   req_ready,
    output logic [HDR_W-1:0]         header_out,
    output logic [CMP_W-1:0]         compare_value_out,
    output logic                     start_out,
    output logic [2:0]               thread_id_out,
    input  logic                     action_done_in,
    input  logic [3:0]               action_in,
    input  logic [2:0]               thread_id_in,
    output logic [NUM_THREADS-1:0]   rsp_valid,
    output logic [NUM_THREADS*4-1:0] rsp_action,
    input  logic [NUM_THREADS-1:0]   rsp_ack,
    output logic                     err_unexpected,
    output logic [15:0]              stat_grants,
    output logic [15:0]              stat_matches
);

    localparam int TID_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t             state [NUM_THREADS];
    logic [TID_W-1:0]   ptr;
    logic [NUM_THREADS-1:0] eligible;
    logic               grant_vld;
    logic [TID_W-1:0]   grant_id;
    logic               done_ok;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            req_ready[i] = (state[i] == IDLE);
        end
    end

    assign eligible = req_valid & req_ready;

    // First eligible thread at or after ptr, wrapping around the thread count.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        for (int k = 0; k < NUM_THREADS; k++) begin
            if (!grant_vld && eligible[(int'(ptr) + k) % NUM_THREADS]) begin
                grant_vld = 1'b1;
                grant_id  = TID_W'((int'(ptr) + k) % NUM_THREADS);
            end
        end
    end

    // A completion is only accepted for a thread that is actually waiting on one.
    assign done_ok = action_done_in && (state[thread_id_in] == PENDING);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_THREADS; i++) begin
                state[i] <= IDLE;
            end
            ptr               <= '0;
            start_out         <= 1'b0;
            header_out        <= '0;
            compare_value_out <= '0;
            thread_id_out     <= '0;
            rsp_valid         <= '0;
            rsp_action        <= '0;
            err_unexpected    <= 1'b0;
        end else begin
            start_out <= grant_vld;
            if (grant_vld) begin
                ptr               <= TID_W'((int'(grant_id) + 1) % NUM_THREADS);
                header_out        <= req_header[int'(grant_id)*HDR_W +: HDR_W];
                compare_value_out <= req_compare[int'(grant_id)*CMP_W +: CMP_W];
                thread_id_out     <= grant_id;
            end
            if (action_done_in && !done_ok) begin
                err_unexpected <= 1'b1;
            end
            // Grant targets an IDLE thread and completion a PENDING one, so the
            // branches never compete for the same thread.
            for (int i = 0; i < NUM_THREADS; i++) begin
                if (grant_vld && grant_id == TID_W'(i)) begin
                    state[i] <= PENDING;
                end else if (done_ok && thread_id_in == TID_W'(i)) begin
                    state[i]           <= DONE;
                    rsp_valid[i]       <= 1'b1;
                    rsp_action[i*4 +: 4] <= action_in;
                end else if (rsp_ack[i] && state[i] == DONE) begin
                    // rsp_action deliberately keeps the last result after the ack.
                    state[i]     <= IDLE;
                    rsp_valid[i] <= 1'b0;
                end
            end
        end
    end

`ifdef ACCEL_DISPATCH_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_grants  <= '0;
            stat_matches <= '0;
        end else begin
            if (grant_vld) begin
                stat_grants <= stat_grants + 16'd1;
            end
            if (done_ok && action_in == 4'b1111) begin
                stat_matches <= stat_matches + 16'd1;
            end
        end
    end
`else
    assign stat_grants  = '0;
    assign stat_matches = '0;
`endif

endmodule

// File: tb/tb_accel_dispatch.sv
// Purpose : scoreboard bench for accel_dispatch; issues and results are checked by a monitor against queued expectations.
// Latency : expectations follow the grant / start / completion / rsp_valid cycle sequence.
// Backpres: the bench plays the accelerator and the threads, acknowledging results explicitly.
module tb_accel_dispatch;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [7:0]   req_valid = '0;
    logic [511:0] req_header = '0;
    logic [255:0] req_compare = '0;
    logic [7:0]   req_ready;
    logic [63:0]  header_out;
    logic [31:0]  compare_value_out;
    logic         start_out;
    logic [2:0]   thread_id_out;
    logic         action_done_in = 1'b0;
    logic [3:0]   action_in = '0;
    logic [2:0]   thread_id_in = '0;
    logic [7:0]   rsp_valid;
    logic [31:0]  rsp_action;
    logic [7:0]   rsp_ack = '0;
    logic         err_unexpected;
    logic [15:0]  stat_grants;
    logic [15:0]  stat_matches;

    accel_dispatch dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_header(req_header), .req_compare(req_compare),
        .req_ready(req_ready),
        .header_out(header_out), .compare_value_out(compare_value_out),
        .start_out(start_out), .thread_id_out(thread_id_out),
        .action_done_in(action_done_in), .action_in(action_in), .thread_id_in(thread_id_in),
        .rsp_valid(rsp_valid), .rsp_action(rsp_action), .rsp_ack(rsp_ack),
        .err_unexpected(err_unexpected),
        .stat_grants(stat_grants), .stat_matches(stat_matches)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  tid;
        logic [63:0] hdr;
        logic [31:0] cmp;
    } iss_t;

    typedef struct {
        logic [2:0] tid;
        logic [3:0] act;
    } rsp_t;

    iss_t iss_q[$];
    rsp_t rsp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    logic [7:0] prev_rv = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops expectations whenever the DUT issues or raises a result.
    always @(negedge clk) begin
        if (!reset) begin
            if (start_out) begin
                if (iss_q.size() == 0) begin
                    chk("spurious_issue", 64'(start_out), 64'd0);
                end else begin
                    iss_t e;
                    e = iss_q.pop_front();
                    chk("issue_tid", 64'(thread_id_out), 64'(e.tid));
                    chk("issue_hdr", header_out, e.hdr);
                    chk("issue_cmp", 64'(compare_value_out), 64'(e.cmp));
                end
            end
            for (int i = 0; i < 8; i++) begin
                if (rsp_valid[i] && !prev_rv[i]) begin
                    if (rsp_q.size() == 0) begin
                        chk("spurious_rsp", 64'(rsp_valid[i]), 64'd0);
                    end else begin
                        rsp_t r;
                        r = rsp_q.pop_front();
                        chk("rsp_tid", 64'(i), 64'(r.tid));
                        chk("rsp_action", 64'(rsp_action[i*4 +: 4]), 64'(r.act));
                    end
                end
            end
        end
        prev_rv = rsp_valid;
    end

    function automatic logic [63:0] hdr_of(input int t);
        return {32'hC0DE_0000 | 32'(t), 32'h1234_5600 | 32'(t)};
    endfunction

    function automatic logic [31:0] cmp_of(input int t);
        return 32'hA5A5_0000 | 32'(t * 17);
    endfunction

    task automatic set_req(input int t, input logic [63:0] h, input logic [31:0] c);
        req_header[t*64 +: 64] = h;
        req_compare[t*32 +: 32] = c;
        req_valid[t] = 1'b1;
        iss_q.push_back('{tid: 3'(t), hdr: h, cmp: c});
    endtask

    // Single request: returns in cycle 2 of the issue (start_out was cycle 1).
    task automatic issue(input int t, input logic [63:0] h, input logic [31:0] c);
        set_req(t, h, c);
        tick();
        chk("ready_low_c1", 64'(req_ready[t]), 64'd0);
        req_valid[t] = 1'b0;
        tick();
    endtask

    task automatic complete(input int t, input logic [3:0] a);
        action_done_in = 1'b1;
        thread_id_in = 3'(t);
        action_in = a;
        rsp_q.push_back('{tid: 3'(t), act: a});
        tick();
        action_done_in = 1'b0;
        chk("rsp_valid_set", 64'(rsp_valid[t]), 64'd1);
    endtask

    task automatic ack(input int t);
        rsp_ack[t] = 1'b1;
        tick();
        rsp_ack[t] = 1'b0;
        chk("ready_after_ack", 64'(req_ready[t]), 64'd1);
        chk("rsp_clr_after_ack", 64'(rsp_valid[t]), 64'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] acts [8];
        acts = '{4'h1, 4'h2, 4'h3, 4'hF, 4'h5, 4'h6, 4'h7, 4'hF};

        do_reset();
        chk("rst_ready", 64'(req_ready), 64'hFF);
        chk("rst_start", 64'(start_out), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_action", 64'(rsp_action), 64'd0);
        chk("rst_err", 64'(err_unexpected), 64'd0);
        chk("rst_hdr", header_out, 64'd0);
        chk("rst_tid", 64'(thread_id_out), 64'd0);
        chk("rst_grants", 64'(stat_grants), 64'd0);

        // Single request from thread 2.
        issue(2, 64'h0000_C0A8_0101_0000, 32'hC0A8_0101);
        chk("single_no_rsp_c2", 64'(rsp_valid[2]), 64'd0);
        complete(2, 4'hF);
        chk("single_action", 64'(rsp_action[11:8]), 64'hF);
        ack(2);
        chk("single_action_kept", 64'(rsp_action[11:8]), 64'hF);

        // Fairness from ptr = 0.
        do_reset();
        for (int t = 0; t < 8; t++) set_req(t, hdr_of(t), cmp_of(t));
        for (int t = 0; t < 8; t++) begin
            tick();
            chk("fair_start_run", 64'(start_out), 64'd1);
        end
        req_valid = '0;
        tick();
        chk("fair_start_end", 64'(start_out), 64'd0);
`ifdef ACCEL_DISPATCH_STATS_EN
        chk("fair_grants", 64'(stat_grants), 64'd8);
`else
        chk("fair_grants", 64'(stat_grants), 64'd0);
`endif
        for (int t = 0; t < 8; t++) complete(t, acts[t]);
        chk("fair_all_rsp", 64'(rsp_valid), 64'hFF);
`ifdef ACCEL_DISPATCH_STATS_EN
        chk("fair_matches", 64'(stat_matches), 64'd2);
`else
        chk("fair_matches", 64'(stat_matches), 64'd0);
`endif
        for (int t = 0; t < 8; t++) ack(t);
        chk("fair_all_ready", 64'(req_ready), 64'hFF);

        // Wrap: move ptr to 6 via thread 5, then 1 and 7 request together.
        issue(5, hdr_of(5), cmp_of(5));
        complete(5, 4'h5);
        ack(5);
        set_req(7, hdr_of(7), cmp_of(7));
        set_req(1, hdr_of(1), cmp_of(1));
        tick();
        tick();
        req_valid = '0;
        tick();
        complete(7, 4'h9);
        complete(1, 4'hA);
        ack(7);
        ack(1);
        // ptr is now 2: thread 2 must beat thread 0.
        set_req(2, hdr_of(2) ^ 64'hFF, cmp_of(2));
        set_req(0, hdr_of(0) ^ 64'hFF, cmp_of(0));
        tick();
        tick();
        req_valid = '0;
        tick();
        complete(2, 4'h3);
        complete(0, 4'h4);
        ack(2);
        ack(0);

        // Unexpected completion on idle thread 5.
        action_done_in = 1'b1;
        thread_id_in = 3'd5;
        action_in = 4'hF;
        tick();
        action_done_in = 1'b0;
        chk("unexp_err", 64'(err_unexpected), 64'd1);
        chk("unexp_rsp5", 64'(rsp_valid[5]), 64'd0);
        chk("unexp_ready", 64'(req_ready), 64'hFF);
        tick();
        chk("unexp_sticky", 64'(err_unexpected), 64'd1);

        // Ack and request on thread 3 in the same cycle.
        issue(3, hdr_of(3), cmp_of(3));
        complete(3, 4'h6);
        iss_q.push_back('{tid: 3'd3, hdr: 64'hDEAD_BEEF_0000_0003, cmp: 32'h0303_0303});
        req_header[3*64 +: 64] = 64'hDEAD_BEEF_0000_0003;
        req_compare[3*32 +: 32] = 32'h0303_0303;
        req_valid[3] = 1'b1;
        rsp_ack[3] = 1'b1;
        tick();
        rsp_ack[3] = 1'b0;
        chk("overlap_no_grant", 64'(start_out), 64'd0);
        chk("overlap_ready", 64'(req_ready[3]), 64'd1);
        tick();
        req_valid[3] = 1'b0;
        chk("overlap_grant", 64'(start_out), 64'd1);
        tick();
        complete(3, 4'h2);
        ack(3);

        // Reset with thread 0 DONE and thread 4 PENDING.
        issue(0, hdr_of(0), cmp_of(0));
        complete(0, 4'hC);
        issue(4, hdr_of(4), cmp_of(4));
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_ready", 64'(req_ready), 64'hFF);
        chk("midrst_rsp", 64'(rsp_valid), 64'd0);
        chk("midrst_start", 64'(start_out), 64'd0);
        chk("midrst_err", 64'(err_unexpected), 64'd0);
        chk("midrst_action", 64'(rsp_action), 64'd0);
        tick();
        reset = 1'b0;
        tick();
        issue(6, hdr_of(6), cmp_of(6));
        complete(6, 4'hF);
        ack(6);

        tick();
        tick();
        chk("iss_left", 64'(iss_q.size()), 64'd0);
        chk("rsp_left", 64'(rsp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
